// File: rtl/ram_pixel_loader.sv
// Feeder for the convolution pixel RAM: packs pairs of pixels from a valid/ready
// stream into {high, low} words and writes one frame to addresses 0..DEPTH-1.
module ram_pixel_loader #(
   parameter int unsigned PIX_W  = 4,
   parameter int unsigned WORD_W = 8,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [PIX_W-1:0]  pix_in,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic [WORD_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic              busy,
   output logic              done
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOW,
      S_HIGH,
      S_WRITE,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [PIX_W-1:0]    r_lo;
   logic [WORD_W-1:0]   r_ram_data;
   logic [ADDR_W-1:0]   r_ram_addr;
   logic                r_busy;
   logic                w_pix_ready;
   logic                w_xfer;
   logic                w_ram_we;
   logic                w_done;

   assign w_pix_ready = (r_state == S_LOW) || (r_state == S_HIGH);
   assign w_xfer      = w_pix_ready & pix_valid;

   always_comb begin
      w_next   = r_state;
      w_ram_we = 1'b0;
      w_done   = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_next = S_LOW;
         S_LOW:   if (w_xfer) w_next = S_HIGH;
         S_HIGH:  if (w_xfer) w_next = S_WRITE;
         S_WRITE: begin
            w_ram_we = 1'b1;
            w_next   = (r_ram_addr == LAST_ADDR) ? S_DONE : S_LOW;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state    <= S_IDLE;
         r_lo       <= '0;
         r_ram_data <= '0;
         r_ram_addr <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_ram_addr <= '0;
                  r_busy     <= 1'b1;
               end
            end
            S_LOW: if (w_xfer) r_lo <= pix_in;
            // High nibble goes straight into the word register so ram_data is valid for all of WRITE
            S_HIGH: if (w_xfer) r_ram_data <= {pix_in, r_lo};
            S_WRITE: if (r_ram_addr != LAST_ADDR) r_ram_addr <= r_ram_addr + ADDR_W'(1);
            S_DONE: r_busy <= 1'b0;
            default: ;
         endcase
      end
   end

   assign pix_ready = w_pix_ready;
   assign ram_data  = r_ram_data;
   assign ram_addr  = r_ram_addr;
   assign ram_we    = w_ram_we;
   assign busy      = r_busy;
   assign done      = w_done;

endmodule

// File: tb/tb_ram_pixel_loader.sv
// Directed-sequence bench for ram_pixel_loader with random pixels, a behavioural
// RAM model and per-frame expected words built from pixel pairs.
module tb_ram_pixel_loader;
   localparam int unsigned PIX_W  = 4;
   localparam int unsigned WORD_W = 8;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned NPIX   = 2 * DEPTH;

   logic              clk = 1'b0;
   logic              clr;
   logic              start;
   logic [PIX_W-1:0]  pix_in;
   logic              pix_valid;
   logic              pix_ready;
   logic [WORD_W-1:0] ram_data;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int we_count = 0;
   int done_count = 0;
   int done_cyc = 0;
   int start_cyc = 0;

   logic [WORD_W-1:0] ram_model [DEPTH];
   logic [ADDR_W-1:0] wr_addr_q [$];
   logic [WORD_W-1:0] wr_data_q [$];
   logic [PIX_W-1:0]  px [NPIX];

   ram_pixel_loader #(
      .PIX_W  (PIX_W),
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .start     (start),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .ram_data  (ram_data),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural RAM plus write/done observation, sampled mid-cycle
   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         ram_model[ram_addr] = ram_data;
         wr_addr_q.push_back(ram_addr);
         wr_data_q.push_back(ram_data);
         we_count++;
      end
      if (done === 1'b1) begin
         done_count++;
         done_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send_pix(input logic [PIX_W-1:0] p);
      int unsigned n = 0;
      pix_in    = p;
      pix_valid = 1'b1;
      while (pix_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("ready_wait", (n < 20) ? 1 : 0, 1);
      tick();
      pix_valid = 1'b0;
   endtask

   task automatic wait_done(input int prev);
      int unsigned n = 0;
      while (done_count == prev && n < 60) begin
         tick();
         n++;
      end
      check("done_seen", done_count, prev + 1);
   endtask

   // One frame from px[]; stall_at = pixel index after which valid drops for 5 cycles.
   // noise keeps start high throughout; keep_start leaves start high into IDLE.
   task automatic run_frame(input int stall_at, input bit noise, input bit keep_start);
      int wc0 = we_count;
      int dc0 = done_count;
      logic [WORD_W-1:0] w0;
      wr_addr_q.delete();
      wr_data_q.delete();
      start     = 1'b1;
      start_cyc = cyc;
      tick();
      start = noise;
      check("start_busy", busy, 1);
      check("start_addr", ram_addr, 0);
      check("start_ready", pix_ready, 1);
      for (int i = 0; i < int'(NPIX); i++) begin
         send_pix(px[i]);
         if (i == stall_at) begin
            w0 = {px[1], px[0]};
            for (int s = 0; s < 5; s++) begin
               tick();
               check("stall_ready", pix_ready, 1);
               check("stall_no_we", ram_we, 0);
               check("stall_data_hold", ram_data, w0);
            end
         end
      end
      wait_done(dc0);
      if (stall_at < 0) check("done_latency", done_cyc - start_cyc, 3 * DEPTH + 1);
      check("done_busy", busy, 1);
      check("we_count", we_count - wc0, DEPTH);
      for (int k = 0; k < int'(DEPTH) && k < wr_addr_q.size(); k++) begin
         check("wr_addr", wr_addr_q[k], k);
         check("wr_data", wr_data_q[k], {px[2*k+1], px[2*k]});
      end
      tick();
      check("idle_busy", busy, 0);
      check("idle_ready", pix_ready, 0);
      check("idle_done", done, 0);
      check("idle_addr_hold", ram_addr, DEPTH - 1);
      check("idle_data_hold", ram_data, {px[NPIX-1], px[NPIX-2]});
      if (!keep_start) start = 1'b0;
   endtask

   task automatic rand_px();
      for (int i = 0; i < int'(NPIX); i++) px[i] = PIX_W'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int wc;
      clr       = 1'b1;
      start     = 1'b0;
      pix_valid = 1'b0;
      pix_in    = '0;

      // Reset with random inputs
      for (int r = 0; r < 2; r++) begin
         start     = 1'($urandom_range(0, 1));
         pix_valid = 1'($urandom_range(0, 1));
         pix_in    = PIX_W'($urandom);
         tick();
         check("reset_outputs", {pix_ready, ram_data, ram_addr, ram_we, busy, done}, 0);
      end
      check("reset_no_we", we_count, 0);
      clr       = 1'b0;
      start     = 1'b0;
      pix_valid = 1'b0;
      tick();
      check("idle_after_reset", {pix_ready, busy, done, ram_we}, 0);

      // Full frame, pixels 1..8
      for (int i = 0; i < int'(NPIX); i++) px[i] = PIX_W'(i + 1);
      run_frame(-1, 1'b0, 1'b0);
      check("ram_word0", ram_model[0], 8'h21);
      check("ram_word3", ram_model[3], 8'h87);

      // Same frame with a 5-cycle valid gap between pixels 3 and 4
      run_frame(2, 1'b0, 1'b0);
      for (int k = 0; k < int'(DEPTH); k++) check("stall_ram", ram_model[k], {px[2*k+1], px[2*k]});

      // clr during HIGH of word 2
      rand_px();
      start = 1'b1;
      tick();
      start = 1'b0;
      wc = we_count;
      for (int i = 0; i < 3; i++) send_pix(px[i]);
      check("pre_clr_busy", busy, 1);
      check("pre_clr_ready", pix_ready, 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_state", {pix_ready, ram_data, ram_addr, ram_we, busy, done}, 0);
      for (int s = 0; s < 3; s++) tick();
      check("clr_partial_writes", we_count - wc, 1);
      check("clr_still_idle", {pix_ready, busy}, 0);
      for (int i = 0; i < int'(NPIX); i++) px[i] = PIX_W'(15 - i);
      run_frame(-1, 1'b0, 1'b0);
      check("reload_first_word", ram_model[0], 8'hEF);

      // start held high during LOW/HIGH/WRITE/DONE must be ignored
      rand_px();
      run_frame(-1, 1'b1, 1'b0);
      tick();
      check("noise_idle_busy", busy, 0);
      check("noise_no_extra_we", ram_we, 0);

      // Back-to-back frames with start held high
      rand_px();
      run_frame(-1, 1'b0, 1'b1);
      rand_px();
      run_frame(-1, 1'b0, 1'b0);
      for (int k = 0; k < int'(DEPTH); k++) check("readback", ram_model[k], {px[2*k+1], px[2*k]});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
